// File: rtl/divider_trim_sar_cal.sv
// Successive-approximation calibration controller for the 5-bit divider trim.
// Enables the divider and comparator, then resolves the trim code MSB first.
// Each trial settles, then takes a majority vote of synchronised comparator samples.
// A final verify vote at the chosen code is reported on cal_hi.
module divider_trim_sar_cal #(
  parameter int          EN_WAIT    = 16,
  parameter int          SETTLE_CYC = 8,
  parameter int          NSAMP      = 3,
  parameter logic [4:0]  POL_MASK   = 5'b10000,
  parameter logic [4:0]  TRIM_RST   = 5'b00000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       ovr_en,
  input  logic [4:0] ovr_trim,
  input  logic       cmp_in,
  output logic       div_en,
  output logic       cmp_en,
  output logic [4:0] trim,
  output logic       busy,
  output logic       done,
  output logic       cal_hi
);

  typedef enum logic [3:0] {
    S_IDLE, S_ENWAIT, S_TRIAL, S_SETTLE, S_SAMPLE,
    S_DECIDE, S_VSETTLE, S_VSAMPLE, S_DONE
  } state_t;

  // Terminal counts are one less than the dwell length because cnt starts at 0
  localparam logic [7:0] EN_LAST  = 8'(EN_WAIT - 1);
  localparam logic [7:0] SET_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] SMP_LAST = 8'(NSAMP - 1);
  localparam logic [4:0] NSAMP_W  = 5'(NSAMP);

  state_t     state, state_n;
  logic [4:0] u, u_n;
  logic [2:0] k, k_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] ones, ones_n;
  logic       cal_hi_n;
  logic       sync1, cmp_s;
  logic [3:0] ones_inc;
  logic       maj_now, maj_inc, in_busy;

  assign in_busy  = (state != S_IDLE) && (state != S_DONE);
  assign ones_inc = ones + {3'b000, cmp_s};
  assign maj_now  = {ones, 1'b0} > NSAMP_W;
  assign maj_inc  = {ones_inc, 1'b0} > NSAMP_W;

  assign busy   = in_busy;
  assign cmp_en = in_busy;
  assign div_en = in_busy || (state == S_DONE);
  assign done   = (state == S_DONE);

  // Trim output: override wins, otherwise reset code in IDLE, else the polarity-mapped up-code
  always_comb begin
    trim = u ^ ~POL_MASK;
    if (ovr_en)
      trim = ovr_trim;
    else if (state == S_IDLE)
      trim = TRIM_RST;
  end

  // Two-flop synchroniser for the asynchronous comparator output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      cmp_s <= 1'b0;
    end else begin
      sync1 <= cmp_in;
      cmp_s <= sync1;
    end
  end

  // Next-state logic: SAR sequencing, dwell counting and majority voting
  always_comb begin
    state_n  = state;
    u_n      = u;
    k_n      = k;
    cnt_n    = cnt + 8'd1;
    ones_n   = ones;
    cal_hi_n = cal_hi;
    case (state)
      S_IDLE, S_DONE: begin
        cnt_n = 8'd0;
        if (start && !ovr_en) begin
          state_n  = S_ENWAIT;
          u_n      = 5'd0;
          k_n      = 3'd4;
          ones_n   = 4'd0;
          cal_hi_n = 1'b0;
        end
      end
      S_ENWAIT: begin
        if (cnt == EN_LAST) begin
          state_n = S_TRIAL;
          k_n     = 3'd4;
          cnt_n   = 8'd0;
        end
      end
      S_TRIAL: begin
        u_n[k]  = 1'b1;
        state_n = S_SETTLE;
        cnt_n   = 8'd0;
      end
      S_SETTLE: begin
        if (cnt == SET_LAST) begin
          state_n = S_SAMPLE;
          cnt_n   = 8'd0;
        end
      end
      S_SAMPLE: begin
        ones_n = ones_inc;
        if (cnt == SMP_LAST) begin
          state_n = S_DECIDE;
          cnt_n   = 8'd0;
        end
      end
      S_DECIDE: begin
        if (maj_now)
          u_n[k] = 1'b0;
        ones_n = 4'd0;
        cnt_n  = 8'd0;
        if (k == 3'd0) begin
          state_n = S_VSETTLE;
        end else begin
          k_n     = k - 3'd1;
          state_n = S_TRIAL;
        end
      end
      S_VSETTLE: begin
        if (cnt == SET_LAST) begin
          state_n = S_VSAMPLE;
          cnt_n   = 8'd0;
        end
      end
      S_VSAMPLE: begin
        ones_n = ones_inc;
        if (cnt == SMP_LAST) begin
          cal_hi_n = maj_inc;
          state_n  = S_DONE;
          cnt_n    = 8'd0;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 8'd0;
      end
    endcase
    if (abort && in_busy) begin
      state_n  = S_IDLE;
      u_n      = 5'd0;
      k_n      = 3'd4;
      cnt_n    = 8'd0;
      ones_n   = 4'd0;
      cal_hi_n = cal_hi;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      u      <= 5'd0;
      k      <= 3'd4;
      cnt    <= 8'd0;
      ones   <= 4'd0;
      cal_hi <= 1'b0;
    end else begin
      state  <= state_n;
      u      <= u_n;
      k      <= k_n;
      cnt    <= cnt_n;
      ones   <= ones_n;
      cal_hi <= cal_hi_n;
    end
  end

endmodule

// File: tb/tb_divider_trim_sar_cal.sv
// Bench for divider_trim_sar_cal: a comparator stub closes the loop through trim,
// a scoreboard queue holds expected results and a monitor checks each done rise.
module tb_divider_trim_sar_cal;

  logic       clk = 1'b0;
  logic       rst, start, abort, ovr_en, cmp_in;
  logic [4:0] ovr_trim;
  logic       div_en, cmp_en, busy, done, cal_hi;
  logic [4:0] trim;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0     = 0;
  int mode   = 0;

  typedef struct {
    logic [4:0] trim;
    logic       hi;
    int         done_edge;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic done_q = 1'b0;
  logic [4:0] u_seen;
  int rel_c;

  divider_trim_sar_cal dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .ovr_en(ovr_en), .ovr_trim(ovr_trim), .cmp_in(cmp_in),
    .div_en(div_en), .cmp_en(cmp_en), .trim(trim),
    .busy(busy), .done(done), .cal_hi(cal_hi)
  );

  // Free-running clock and posedge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparator stub: recover the up-code from trim and compare against the target
  always @* begin
    u_seen = trim ^ 5'b01111;
    rel_c  = cyc - t0;
    case (mode)
      1:       cmp_in = 1'b1;
      2:       cmp_in = 1'b0;
      3:       cmp_in = (u_seen > 5'd18) &&
                        !((rel_c >= 24 && rel_c <= 76 && ((rel_c - 24) % 13) == 0) || rel_c == 88);
      default: cmp_in = (u_seen > 5'd18);
    endcase
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Launch a calibration (start sampled at edge 0) and optionally queue its expected outcome
  task automatic applyStimulus(input bit push, input logic [4:0] exp_trim, input logic exp_hi);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
    if (push) begin
      e.trim      = exp_trim;
      e.hi        = exp_hi;
      e.done_edge = 92;
      sb.push_back(e);
    end
  endtask

  // Full run: launch, optionally pulse start at edges 10 and 50, wait for done with a bound
  task automatic run_cal(input logic [4:0] exp_trim, input logic exp_hi, input bit pulses);
    int bc = 0;
    int rel;
    bit seen = 1'b0;
    applyStimulus(1'b1, exp_trim, exp_hi);
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (pulses) start = (rel == 9 || rel == 49);
      if (done) seen = 1'b1;
      else if (busy) bc++;
    end
    start = 1'b0;
    checkOutput("done_seen", seen, 1);
    checkOutput("busy_cycles", bc, 92);
    checkOutput("busy_low_in_done", busy, 0);
    @(negedge clk);
  endtask

  // Monitor: on every rising done, pop the scoreboard and compare the result
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        checkOutput("sb_has_entry", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("done_trim", trim, mon_e.trim);
        checkOutput("done_cal_hi", cal_hi, mon_e.hi);
        checkOutput("done_edge", cyc - t0, mon_e.done_edge);
        checkOutput("done_div_en", div_en, 1);
        checkOutput("done_cmp_en", cmp_en, 0);
      end
    end
    done_q <= done;
  end

  // Hard stop in case something never returns
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ovr_en = 1'b0; ovr_trim = 5'd0; mode = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_trim", trim, 0);
    checkOutput("rst_flags", {div_en, cmp_en, busy, done, cal_hi}, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] target u>18");
    mode = 0; run_cal(5'b11101, 1'b0, 1'b0);
    $display("[TB] comparator stuck high");
    mode = 1; run_cal(5'b01111, 1'b1, 1'b0);
    $display("[TB] comparator stuck low");
    mode = 2; run_cal(5'b10000, 1'b0, 1'b0);
    $display("[TB] glitch on middle sample");
    mode = 3; run_cal(5'b11101, 1'b0, 1'b0);
    $display("[TB] start pulses while busy");
    mode = 0; run_cal(5'b11101, 1'b0, 1'b1);

    $display("[TB] abort mid-run");
    applyStimulus(1'b0, 5'd0, 1'b0);
    repeat (41) @(negedge clk);
    checkOutput("busy_before_abort", busy, 1);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    checkOutput("abort_trim", trim, 0);
    checkOutput("abort_flags", {div_en, cmp_en, busy, done}, 0);
    run_cal(5'b11101, 1'b0, 1'b0);

    $display("[TB] override in DONE");
    @(negedge clk);
    ovr_en = 1'b1; ovr_trim = 5'b00101;
    #1;
    checkOutput("ovr_trim", trim, 5'b00101);
    start = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("ovr_start_busy", busy, 0);
    checkOutput("ovr_start_done", done, 1);
    start = 1'b0; ovr_en = 1'b0;
    #1;
    checkOutput("ovr_release_trim", trim, 5'b11101);

    $display("[TB] reset mid-run");
    applyStimulus(1'b0, 5'd0, 1'b0);
    repeat (30) @(negedge clk);
    checkOutput("busy_before_rst", busy, 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_mid_trim", trim, 0);
    checkOutput("rst_mid_flags", {div_en, cmp_en, busy, done, cal_hi}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
